conf_regfile_shadowed: RTL
==========================

Name: conf_regfile_shadowed

Overview:
Parametrised, double-buffered configuration register bank for the accelerator control path. It generalises the single-bank config file in four ways: configurable depth and width, byte-strobed writes, registered readback, and a shadow/active split. Host writes land in the shadow bank. The shadow bank is copied atomically into the active bank only on a commit, and only when the datapath is not mid-layer, so a layer never sees a half-updated configuration. The active bank drives the flattened configuration bus to the layer controllers (FC pointer, log index, frame-by-frame mode, etc.).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
NUM_REGS, 16, number of configuration registers.
ADDR_W, 32, width of external address ports; only the low clog2(NUM_REGS) bits index the bank, and the upper bits must be zero.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_en_ext  in  1  write strobe, one write per cycle
wr_addr_ext  in  ADDR_W  write register index
wr_data_ext  in  DATA_W  write data
wr_strb_ext  in  DATA_W/8  byte enables for the write
rd_en_ext  in  1  read request
rd_addr_ext  in  ADDR_W  read register index
rd_bank_sel  in  1  read source: 0 = shadow, 1 = active
rd_data_ext  out  DATA_W  read data
rd_valid_ext  out  1  read data valid
commit_req  in  1  request to copy shadow into active (pulse)
layer_busy  in  1  datapath is executing a layer; commit must wait
commit_pending  out  1  a commit is queued behind layer_busy
commit_ack  out  1  one-cycle pulse in the first cycle the new active values are visible
conf_active  out  NUM_REGS*DATA_W  active bank, register i at bits [i*DATA_W +: DATA_W]
addr_err  out  1  sticky out-of-range access flag
err_clr  in  1  clears addr_err

Behaviour:
- Reset (synchronous, active-high, on the clk edge): both banks are zero and the FSM goes to IDLE. All outputs are 0: rd_data_ext, rd_valid_ext, commit_ack, commit_pending, addr_err and conf_active. Reset overrides every other input, including a commit in flight; a queued commit is discarded.
- Write: if wr_en_ext is high and wr_addr_ext < NUM_REGS, then for each byte b with wr_strb_ext[b]=1, shadow[addr] byte b takes wr_data_ext byte b at the edge. Strobe all-zero is a legal no-op.
- Out-of-range write or read (address >= NUM_REGS, upper bits included): the access is ignored and addr_err is set the next cycle.
- addr_err: err_clr clears it. If err_clr and a new error occur in the same cycle, the set wins.
- Read: 1-cycle latency. rd_valid_ext=1 and rd_data_ext=selected bank[addr] in the cycle after rd_en_ext. An out-of-range read returns rd_valid_ext=1 with rd_data_ext=0. rd_data_ext holds its value while rd_valid_ext=0.
- Read/write same cycle, same address, shadow bank: returns the pre-write value; there is no bypass.
- Commit FSM states: IDLE, PENDING.
  - IDLE with commit_req=1 and layer_busy=0: active <= shadow at this edge; commit_ack=1 next cycle; stay in IDLE.
  - IDLE with commit_req=1 and layer_busy=1: go to PENDING; commit_pending=1 from the next cycle.
  - PENDING with layer_busy=0: copy at this edge, commit_ack=1 next cycle, return to IDLE, commit_pending drops with the ack.
  - PENDING with commit_req=1: the request is absorbed, giving a single copy and a single ack.
- Copy semantics: the copy captures the shadow contents as of before that edge. A write in the same cycle as the copy lands in shadow only and is not in active until the next commit.
- Copy-through: writes made while PENDING are included in the eventual copy.
- Timing: commit_ack is a registered one-cycle pulse. conf_active changes only on a copy edge or reset, and is never glitch-updated per register.
- Minimum commit latency: request at edge N, new active values and ack visible in cycle N+1.

Decomposition:
- Shared package: DATA_W and NUM_REGS defaults, the derived IDX_W = clog2(NUM_REGS), the commit FSM enum (IDLE, PENDING), and named register indices (FC memory pointer = 0, FC log index = 1, frame-by-frame mode = 2).
- One natural sub-module, conf_bank: a single strobed register array with a registered read port. It is instantiated twice, as shadow and active. The active instance takes a full-width parallel load from shadow.

Test Plan:
- Reset then idle: every conf_active word reads 0; reading active[2] gives rd_valid=1, data=0 one cycle later.
- Write shadow[2]=0xDEADBEEF, strb=0xF; read shadow[2] gives 0xDEADBEEF; active[2] stays 0. Then commit with layer_busy=0: the next cycle shows commit_ack=1 and active[2]=0xDEADBEEF.
- Strobed write 0x000000AA with strb=0x1 over 0x11223344 gives 0x112233AA.
- Defer and absorb: hold layer_busy=1 and pulse commit_req twice, giving commit_pending=1 and no copy. Write shadow[0]=0x40 while pending. Drop layer_busy: exactly one ack, and active[0]=0x40.
- Same-cycle write and copy: write shadow[1]=0x5 in the copy cycle; active[1] keeps the old value and shadow[1]=0x5.
- Out-of-range write to address NUM_REGS (16) and to 0x100: no register changes and addr_err=1. Then err_clr concurrent with another bad read: addr_err stays 1. A clean err_clr clears it.
- Assert reset while PENDING: pending clears, no ack, both banks are zero.

Source files
------------

// File: rtl/conf_regfile_shadowed_pkg.sv
// Shared defaults, commit FSM encoding and named register indices for the shadowed config bank.
package conf_regfile_shadowed_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned IDX_W        = (DEF_NUM_REGS > 1) ? $clog2(DEF_NUM_REGS) : 1;

  localparam int unsigned REG_FC_MEM_PTR = 0;
  localparam int unsigned REG_FC_LOG_IDX = 1;
  localparam int unsigned REG_FBF_MODE   = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } commit_state_t;

endpackage

// File: rtl/conf_bank.sv
// Byte-strobed register array with a registered read port and a full-width parallel load.
module conf_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic                       load_en,
  input  logic [NUM_REGS*DATA_W-1:0] load_data,
  input  logic                       rd_en,
  input  logic [IDX_W-1:0]           rd_idx,
  input  logic                       rd_zero,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] flat
);

  localparam int unsigned NUM_BYTES = DATA_W / 8;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Parallel load takes priority; a bank is only ever driven by one of the two paths.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= load_data[i*DATA_W +: DATA_W];
    end else if (wr_en) begin
      for (int b = 0; b < int'(NUM_BYTES); b++) begin
        if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Read port holds its last value between requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : regs[rd_idx];
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) flat[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: rtl/conf_regfile_shadowed.sv
// Double-buffered config register bank: host writes go to shadow, commits copy shadow to active between layers.
module conf_regfile_shadowed
  import conf_regfile_shadowed_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_ext,
  input  logic [ADDR_W-1:0]          wr_addr_ext,
  input  logic [DATA_W-1:0]          wr_data_ext,
  input  logic [DATA_W/8-1:0]        wr_strb_ext,
  input  logic                       rd_en_ext,
  input  logic [ADDR_W-1:0]          rd_addr_ext,
  input  logic                       rd_bank_sel,
  output logic [DATA_W-1:0]          rd_data_ext,
  output logic                       rd_valid_ext,
  input  logic                       commit_req,
  input  logic                       layer_busy,
  output logic                       commit_pending,
  output logic                       commit_ack,
  output logic [NUM_REGS*DATA_W-1:0] conf_active,
  output logic                       addr_err,
  input  logic                       err_clr
);

  localparam int unsigned BANK_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  commit_state_t state_q, state_d;
  logic          copy_c;

  logic                       wr_in_range_c, rd_in_range_c;
  logic [BANK_IDX_W-1:0]      wr_idx_c, rd_idx_c;
  logic [DATA_W-1:0]          shadow_rd, active_rd;
  logic [NUM_REGS*DATA_W-1:0] shadow_flat;
  logic                       rd_sel_q;

  // Full-width compare so any nonzero upper address bit counts as out of range.
  assign wr_in_range_c = (wr_addr_ext < ADDR_W'(NUM_REGS));
  assign rd_in_range_c = (rd_addr_ext < ADDR_W'(NUM_REGS));
  assign wr_idx_c      = BANK_IDX_W'(wr_addr_ext);
  assign rd_idx_c      = BANK_IDX_W'(rd_addr_ext);

  conf_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (BANK_IDX_W)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en_ext & wr_in_range_c),
    .wr_idx    (wr_idx_c),
    .wr_data   (wr_data_ext),
    .wr_strb   (wr_strb_ext),
    .load_en   (1'b0),
    .load_data ('0),
    .rd_en     (rd_en_ext & ~rd_bank_sel),
    .rd_idx    (rd_idx_c),
    .rd_zero   (~rd_in_range_c),
    .rd_data   (shadow_rd),
    .flat      (shadow_flat)
  );

  conf_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (BANK_IDX_W)
  ) u_active (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .wr_strb   ('0),
    .load_en   (copy_c),
    .load_data (shadow_flat),
    .rd_en     (rd_en_ext & rd_bank_sel),
    .rd_idx    (rd_idx_c),
    .rd_zero   (~rd_in_range_c),
    .rd_data   (active_rd),
    .flat      (conf_active)
  );

  // Commit FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and copy strobe; a request while pending is absorbed.
  always_comb begin
    state_d = state_q;
    copy_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (commit_req) begin
          if (layer_busy) state_d = PENDING;
          else            copy_c  = 1'b1;
        end
      end
      PENDING: begin
        if (!layer_busy) begin
          copy_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_ack     <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      commit_ack     <= copy_c;
      commit_pending <= (state_d == PENDING);
    end
  end

  // Sticky error flag; a new error beats a concurrent clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if ((wr_en_ext && !wr_in_range_c) || (rd_en_ext && !rd_in_range_c)) begin
      addr_err <= 1'b1;
    end else if (err_clr) begin
      addr_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_ext <= 1'b0;
      rd_sel_q     <= 1'b0;
    end else begin
      rd_valid_ext <= rd_en_ext;
      if (rd_en_ext) rd_sel_q <= rd_bank_sel;
    end
  end

  // Both bank read registers hold, so the selected one is stable while rd_valid_ext is low.
  assign rd_data_ext = rd_sel_q ? active_rd : shadow_rd;

endmodule
